sprite_bram_loader: RTL and testbench

//  Writer side of the two-bank palette-index sprite image RAM (8-bit entries, depth 2*WIDTH*HEIGHT).

---
 rtl/sprite_bram_loader.sv | 126 ++++++++++++
 tb/tb_sprite_bram_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_bram_loader.sv
// rtl/sprite_bram_loader.sv - byte-stream writer for the two-bank sprite image RAM
// Optional running byte checksum enabled by defining SPRITE_LOADER_CHECKSUM_EN.
module sprite_bram_loader #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    localparam int ADDR_W = $clog2(WIDTH*HEIGHT) + 1
) (
    input  logic              pixel_clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              bank_in,
    input  logic [7:0]        s_data_in,
    input  logic              s_valid_in,
    input  logic              s_last_in,
    output logic              s_ready_out,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [7:0]        wr_data_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    output logic              loaded_bank_out,
    output logic [15:0]       checksum_out
);

    localparam int PIX_W = ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PIX_W-1:0] x;
    logic [PIX_W-1:0] y;
    logic [PIX_W-1:0] pix;
    logic             bank;
    logic             accept;
    logic             start_ok;
    logic             last_x;
    logic             last_y;

    assign s_ready_out = (state == LOAD) || (state == FLUSH);
    assign busy_out    = (state != IDLE);
    assign done_out    = (state == DONE);
    assign accept      = s_valid_in && s_ready_out;
    assign start_ok    = (state == IDLE) && start_in;
    assign last_x      = (x == PIX_W'(WIDTH - 1));
    assign last_y      = (y == PIX_W'(HEIGHT - 1));
    assign pix         = y * PIX_W'(WIDTH) + x;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_in) state_nxt = LOAD;
            LOAD: begin
                if (accept) begin
                    if (last_x && last_y)
                        state_nxt = s_last_in ? DONE : FLUSH;
                    else if (s_last_in)
                        state_nxt = DONE;
                end
            end
            FLUSH: if (accept && s_last_in) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            x               <= '0;
            y               <= '0;
            bank            <= 1'b0;
            wr_en_out       <= 1'b0;
            wr_addr_out     <= '0;
            wr_data_out     <= '0;
            err_out         <= 1'b0;
            loaded_bank_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_en_out <= 1'b0;
            if (start_ok) begin
                bank    <= bank_in;
                x       <= '0;
                y       <= '0;
                err_out <= 1'b0;
            end
            if (state == LOAD && accept) begin
                wr_en_out   <= 1'b1;
                wr_addr_out <= {bank, pix};
                wr_data_out <= s_data_in;
                // y holds on the final pixel so the address can never run past the frame
                if (last_x) begin
                    x <= '0;
                    if (!last_y) y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
                if (last_x && last_y) begin
                    if (!s_last_in) err_out <= 1'b1;
                end else if (s_last_in) begin
                    err_out <= 1'b1;
                end
            end
            if (state == DONE && !err_out) loaded_bank_out <= bank;
        end
    end

`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            sum <= '0;
        else if (start_ok)
            sum <= '0;
        else if (state == LOAD && accept)
            sum <= sum + {8'h00, s_data_in};
    end

    assign checksum_out = sum;
`else
    assign checksum_out = 16'h0000;
`endif

endmodule

// File: tb/tb_sprite_bram_loader.sv
// tb/tb_sprite_bram_loader.sv - directed bench with frame-level reference model for sprite_bram_loader
module tb_sprite_bram_loader;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          bank_in = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          done;
    logic          err;
    logic          loaded;
    logic [15:0]   checksum;

    sprite_bram_loader #(.WIDTH(W), .HEIGHT(H)) dut (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .start_in(start), .bank_in(bank_in),
        .s_data_in(s_data), .s_valid_in(s_valid), .s_last_in(s_last), .s_ready_out(s_ready),
        .wr_en_out(wr_en), .wr_addr_out(wr_addr), .wr_data_out(wr_data), .busy_out(busy),
        .done_out(done), .err_out(err), .loaded_bank_out(loaded), .checksum_out(checksum)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    // Frame-level reference: phase 0 idle, 1 storing pixels, 2 discarding, 3 end-of-frame
    int          ph = 0;
    int          cnt = 0;
    logic        m_bank = 1'b0;
    logic        m_err = 1'b0;
    logic        m_loaded = 1'b0;
    logic [15:0] m_sum = 16'h0;
    logic        e_wr_en = 1'b0;
    int          e_addr = 0;
    logic [7:0]  e_data = 8'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; cnt = 0; m_bank = 0; m_err = 0; m_loaded = 0; m_sum = 0; e_wr_en = 0;
        end else begin
            e_wr_en = 0;
            case (ph)
                0: if (start) begin
                    ph = 1; cnt = 0; m_bank = bank_in; m_err = 0; m_sum = 0;
                end
                1: if (s_valid) begin
                    e_wr_en = 1;
                    e_addr  = (m_bank ? N : 0) + cnt;
                    e_data  = s_data;
                    m_sum   = m_sum + 16'(s_data);
                    cnt++;
                    if (cnt == N) begin
                        if (s_last) ph = 3;
                        else begin ph = 2; m_err = 1; end
                    end else if (s_last) begin
                        ph = 3; m_err = 1;
                    end
                end
                2: if (s_valid && s_last) ph = 3;
                default: begin
                    if (!m_err) m_loaded = m_bank;
                    ph = 0;
                end
            endcase
        end
    end

    function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef SPRITE_LOADER_CHECKSUM_EN
        return s;
`else
        return 16'h0 & s;
`endif
    endfunction

    logic [7:0] dut_mem [0:2*N-1];
    int wr_count = 0;
    int done_seen = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("ready", s_ready, (ph == 1 || ph == 2));
            check("busy", busy, (ph != 0));
            check("done", done, (ph == 3));
            check("err", err, m_err);
            check("loaded_bank", loaded, m_loaded);
            check("wr_en", wr_en, e_wr_en);
            check("checksum", checksum, exp_sum(m_sum));
            if (e_wr_en) begin
                check("wr_addr", wr_addr, e_addr);
                check("wr_data", wr_data, e_data);
            end
            if (wr_en) begin
                dut_mem[wr_addr] = wr_data;
                wr_count++;
            end
            if (done) done_seen++;
        end
    end

    task automatic send_frame(input logic b, input int n, input logic [7:0] base,
                              input int gaps, input int flip_at, input int abort_at);
        int   t;
        logic rdy;
        wr_count = 0;
        done_seen = 0;
        @(posedge clk); #1;
        start = 1; bank_in = b;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps != 0) begin
                s_valid = 0;
                repeat ((i % 2 == 1) ? 1 : int'($urandom_range(0, 2))) begin
                    @(posedge clk); #1;
                end
            end
            s_valid = 1; s_data = base + 8'(i); s_last = (i == n - 1);
            if (i == flip_at) begin start = 1; bank_in = ~b; end
            t = 0;
            do begin
                @(negedge clk); rdy = s_ready;
                @(posedge clk); #1;
                t++;
            end while (!rdy && t < 50);
            start = 0;
            if (!rdy) check("accept_timeout", 0, 1);
            if (i == abort_at) begin
                s_valid = 0; s_last = 0;
                #2; rst_n = 0; #1;
                check("async_reset_outputs",
                      {wr_en, s_ready, busy, done, err, loaded, wr_addr, wr_data, checksum}, 0);
                @(posedge clk); #3; rst_n = 1;
                repeat (3) @(posedge clk); #1;
                return;
            end
        end
        s_valid = 0; s_last = 0;
        t = 0;
        while (done_seen == 0 && t < 50) begin @(negedge clk); t++; end
        if (done_seen == 0) check("done_timeout", 0, 1);
        repeat (2) @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 2*N; i++) dut_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {wr_en, s_ready, busy, done, err, loaded, wr_addr, wr_data, checksum}, 0);
        @(negedge clk); #2; rst_n = 1;
        @(posedge clk); #1;

        // 1: clean frame into bank 1
        send_frame(1, 8, 8'h10, 0, -1, -1);
        check("t1_writes", wr_count, 8);
        check("t1_done_pulses", done_seen, 1);
        for (int i = 0; i < 8; i++) check("t1_mem", dut_mem[8+i], 8'h10 + 8'(i));
        check("t1_err", err, 0);
        check("t1_loaded", loaded, 1);
`ifdef SPRITE_LOADER_CHECKSUM_EN
        check("t1_checksum", checksum, 16'h009C);
`else
        check("t1_checksum", checksum, 16'h0000);
`endif

        // 2: same frame with valid gaps
        for (int i = 0; i < 2*N; i++) dut_mem[i] = 8'h00;
        send_frame(1, 8, 8'h10, 1, -1, -1);
        check("t2_writes", wr_count, 8);
        check("t2_done_pulses", done_seen, 1);
        for (int i = 0; i < 8; i++) check("t2_mem", dut_mem[8+i], 8'h10 + 8'(i));

        // 3: short frame into bank 0
        send_frame(0, 5, 8'h20, 0, -1, -1);
        check("t3_writes", wr_count, 5);
        check("t3_mem4", dut_mem[4], 8'h24);
        check("t3_mem5_untouched", dut_mem[5], 8'h00);
        check("t3_err", err, 1);
        check("t3_loaded", loaded, 1);
        check("t3_done_pulses", done_seen, 1);

        // 4: long frame, three beats flushed
        send_frame(0, 11, 8'h30, 0, -1, -1);
        check("t4_writes", wr_count, 8);
        check("t4_mem7", dut_mem[7], 8'h37);
        check("t4_bank1_untouched", dut_mem[8], 8'h10);
        check("t4_err", err, 1);
        check("t4_loaded", loaded, 1);
        check("t4_done_pulses", done_seen, 1);

        // 5: start with flipped bank during load is ignored
        send_frame(0, 8, 8'h40, 0, 3, -1);
        check("t5_writes", wr_count, 8);
        check("t5_mem3", dut_mem[3], 8'h43);
        check("t5_bank1_untouched", dut_mem[11], 8'h13);
        check("t5_err", err, 0);
        check("t5_loaded", loaded, 0);

        // 6: reset after beat 3, then a clean reload
        send_frame(1, 8, 8'h50, 0, -1, 2);
        check("t6_no_done", done_seen, 0);
        check("t6_idle", {busy, s_ready, loaded, err}, 0);
        send_frame(1, 8, 8'h60, 0, -1, -1);
        check("t7_writes", wr_count, 8);
        check("t7_mem15", dut_mem[15], 8'h67);
        check("t7_loaded", loaded, 1);
        check("t7_err", err, 0);
`ifdef SPRITE_LOADER_CHECKSUM_EN
        check("t7_checksum", checksum, 16'h031C);
`else
        check("t7_checksum", checksum, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
